// File: rtl/apb_v3_master.sv
// apb_v3_master: buffered valid/ready command stream to APB3 SETUP/ACCESS transfers with per-transfer timeout
module apb_v3_master #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYC    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_BUS_WIDTH-1:0] PADDR,
    output logic [DATA_BUS_WIDTH-1:0] PWDATA,
    input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    localparam int PW = $clog2(CMD_FIFO_DEPTH);
    localparam int EW = 1 + ADDR_BUS_WIDTH + DATA_BUS_WIDTH;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state, state_next;
    logic [EW-1:0] fifo_mem [CMD_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [TW-1:0] wait_cnt;
    logic          push, pop, done, tmo;

    assign cmd_ready = count != (PW+1)'(CMD_FIFO_DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0) && !rsp_valid;
    assign done      = (state == ACCESS) && PREADY;
    assign tmo       = (state == ACCESS) && !PREADY && (TIMEOUT_CYC != 0) &&
                       (32'(wait_cnt) + 32'd1 == $unsigned(TIMEOUT_CYC));
    assign PSEL      = state != IDLE;
    assign PENABLE   = state == ACCESS;

    // Command storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge PCLK) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // State register; async reset drops PSEL/PENABLE immediately
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else state <= state_next;
    end

    // Next-state: start only with no pending response; SETUP always lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pop ? SETUP : IDLE;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = (done || tmo) ? IDLE : ACCESS;
            default: state_next = IDLE;
        endcase
    end

    // Transfer attributes held from SETUP through the last ACCESS cycle; wait counter per transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            wait_cnt <= '0;
        end else begin
            if (pop) {PWRITE, PADDR, PWDATA} <= fifo_mem[rd_ptr];
            if (state == SETUP) wait_cnt <= '0;
            else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Response register: filled on completion or abort, emptied by the consumer handshake
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (tmo) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_v3_master.sv
// tb_apb_v3_master: scoreboard bench for apb_v3_master against a 64-entry APB SRAM slave model
module tb_apb_v3_master;
    logic        PCLK = 0, PRESETn = 0;
    logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 1;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    typedef struct {logic [31:0] rdata; logic err; logic tmo;} rsp_t;
    rsp_t exp_q[$];

    int checks = 0, errors = 0;
    int setups = 0, en_cyc = 0, rsp_seen = 0;
    logic [31:0] smem [64];
    logic [31:0] mdl [64];
    int ws = 0, acc_cnt = 0;
    logic stuck = 0;
    logic [31:0] lat_a, lat_d;

    apb_v3_master #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .CMD_FIFO_DEPTH(4), .TIMEOUT_CYC(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: PREADY high in SETUP, ws wait cycles in ACCESS, error above 63
    assign PREADY  = !stuck && (!PENABLE || acc_cnt >= ws);
    assign PSLVERR = PSEL && (PADDR >= 64);
    assign PRDATA  = (PADDR < 64) ? smem[PADDR[5:0]] : 32'd0;

    always @(posedge PCLK) begin
        acc_cnt <= (PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR < 64) smem[PADDR[5:0]] <= PWDATA;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pop expected entry on each consumer handshake
    always @(negedge PCLK) begin
        if (PRESETn && rsp_valid && rsp_ready) begin
            rsp_t e;
            rsp_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b tmo=%0b with empty scoreboard",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=0x%0h err=%0b tmo=%0b expected rdata=0x%0h err=%0b tmo=%0b",
                             rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
                end
            end
        end
    end

    // APB monitor: count phases and check address/data stability across ACCESS
    always @(negedge PCLK) begin
        if (PSEL && !PENABLE) begin
            setups++;
            lat_a = PADDR;
            lat_d = PWDATA;
        end
        if (PENABLE) begin
            en_cyc++;
            checks++;
            if (PADDR !== lat_a || PWDATA !== lat_d) begin
                errors++;
                $display("FAIL apb_hold: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                         PADDR, PWDATA, lat_a, lat_d);
            end
        end
    end

    // Issue one command starting at posedge+1; returns at posedge+1 after its handshake edge
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic to);
        rsp_t e;
        logic ok;
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        do begin
            @(negedge PCLK);
            ok = cmd_ready;
            @(posedge PCLK);
            n++;
        end while (!ok && n < 200);
        #1 cmd_valid = 0;
        if (!ok) begin
            errors++; checks++;
            $display("FAIL cmd_handshake: got no cmd_ready expected handshake within 200 cycles");
            return;
        end
        if (to) e = '{32'd0, 1'b1, 1'b1};
        else if (w) begin
            e = '{32'd0, a >= 64, 1'b0};
            if (a < 64) mdl[a[5:0]] = d;
        end else e = '{(a < 64) ? mdl[a[5:0]] : 32'd0, a >= 64, 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int lat = 0;
        do begin
            @(posedge PCLK);
            #1 lat++;
        end while (!rsp_valid && lat < 100);
        chk(name, lat, exp_lat);
    endtask

    initial begin
        int s0, r0, n;
        for (int i = 0; i < 64; i++) begin smem[i] = 0; mdl[i] = 0; end
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1 PRESETn = 1;
        @(posedge PCLK); #1;

        send(1, 3, 32'hA5, 0);
        wait_rsp("lat_write", 3);
        send(0, 3, 0, 0);
        wait_rsp("lat_read", 3);
        @(posedge PCLK); #1;

        ws = 2; en_cyc = 0;
        send(1, 7, 32'h1234_5678, 0);
        wait_rsp("lat_wait", 5);
        chk("wait_penable_cycles", en_cyc, 3);
        ws = 0;
        send(0, 7, 0, 0);
        wait_rsp("lat_read7", 3);
        @(posedge PCLK); #1;

        send(0, 100, 0, 0);
        wait_rsp("lat_err", 3);
        chk("err_flag", rsp_err, 1);
        @(posedge PCLK); #1;

        stuck = 1; en_cyc = 0;
        send(0, 5, 0, 1);
        wait_rsp("lat_timeout", 6);
        chk("timeout_penable_cycles", en_cyc, 4);
        chk("timeout_psel", PSEL, 0);
        stuck = 0;
        @(posedge PCLK); #1;

        rsp_ready = 0;
        s0 = setups;
        send(1, 10, 32'h11, 0);
        send(1, 11, 32'h22, 0);
        send(0, 10, 0, 0);
        send(0, 11, 0, 0);
        send(1, 12, 32'h33, 0);
        chk("full_cmd_ready", cmd_ready, 0);
        repeat (10) @(posedge PCLK);
        #1 chk("backpressure_one_xfer", setups - s0, 1);
        chk("full_hold_cmd_ready", cmd_ready, 0);
        rsp_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge PCLK); n++; end
        #1 chk("drain_xfers", setups - s0, 5);
        chk("drain_cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1;

        stuck = 1;
        send(1, 20, 32'hDEAD, 0);
        n = 0;
        while (!PENABLE && n < 20) begin @(negedge PCLK); n++; end
        chk("reset_reached_access", PENABLE, 1);
        #2 PRESETn = 0;
        #1;
        chk("arst_psel", PSEL, 0);
        chk("arst_penable", PENABLE, 0);
        chk("arst_pwrite", PWRITE, 0);
        chk("arst_paddr", PADDR, 0);
        chk("arst_pwdata", PWDATA, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        mdl[20] = 0;
        s0 = setups; r0 = rsp_seen;
        @(posedge PCLK); #1 PRESETn = 1; stuck = 0;
        repeat (10) @(posedge PCLK);
        #1 chk("post_reset_no_rsp", rsp_seen - r0, 0);
        chk("post_reset_no_xfer", setups - s0, 0);

        send(0, 20, 0, 0);
        wait_rsp("lat_post_reset", 3);
        @(posedge PCLK); #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
